// File: rtl/dig_pkg.sv
// Shared constants for the DIG binary-to-BCD feeder.
// Holds the FSM encoding, CPU address codes and the decimal limits.
// No logic lives here.
package dig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  ADDR_LO  = 2'b00;
  localparam logic [1:0]  ADDR_HI  = 2'b10;
  localparam logic [30:0] DEC_MAX  = 31'd99_999_999;
  localparam logic [31:0] OVF_CODE = 32'hEEEE_EEEE;

endpackage

// File: rtl/bcd_adjust8.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_adjust8 (
  input  logic [31:0] bcd_in,
  output logic [31:0] bcd_out
);

  // Correct each of the 8 nibbles independently before the next shift
  always_comb begin
    bcd_out = bcd_in;
    for (int i = 0; i < 8; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/dig_bcd_feeder.sv
// CPU-facing DIG register pair that converts a committed value to 8 BCD digits (or hex/overflow) for display_tube.
// Latency: commit edge to tube_write pulse is 2 cycles (hex/overflow) or SHIFT_BITS+2 cycles (decimal).
// Backpressure: none; a commit while busy is held as one pending request, later commits only refresh the registers.
module dig_bcd_feeder #(
  parameter int unsigned SHIFT_BITS = 27,
  parameter logic [31:0] OVF_CODE   = dig_pkg::OVF_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digcs,
  input  logic        digwrite,
  input  logic [1:0]  digaddr,
  input  logic [15:0] wdata,
  output logic [31:0] tube_data,
  output logic        tube_write,
  output logic        tube_cs,
  output logic        busy
);
  import dig_pkg::state_t;
  import dig_pkg::IDLE;
  import dig_pkg::LOAD;
  import dig_pkg::SHIFT;
  import dig_pkg::DONE;
  import dig_pkg::ADDR_LO;
  import dig_pkg::ADDR_HI;
  import dig_pkg::DEC_MAX;

  localparam int unsigned CNT_W = $clog2(SHIFT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_BITS - 1);

  state_t            state, state_nxt;
  logic [15:0]       lo_reg, hi_reg;
  logic              pending;
  logic [31:0]       work_q;
  logic [31:0]       acc;
  logic [31:0]       acc_adj;
  logic [CNT_W-1:0]  cnt;

  logic              wr, lo_wr, commit, take_snap, dec_ovf;
  logic [31:0]       raw_nxt;
  logic [31:0]       acc_shift;

  assign wr      = digcs & digwrite;
  assign lo_wr   = wr && (digaddr == ADDR_LO);
  assign commit  = wr && (digaddr == ADDR_HI);
  // Snapshot sees a same-cycle write so the newest register contents win
  assign raw_nxt = {(commit ? wdata : hi_reg), (lo_wr ? wdata : lo_reg)};
  assign take_snap = ((state == IDLE) && commit) || ((state == DONE) && (pending || commit));
  assign dec_ovf = (work_q[30:0] > DEC_MAX);

  bcd_adjust8 u_adj (
    .bcd_in  (acc),
    .bcd_out (acc_adj)
  );

  assign acc_shift = (acc_adj << 1) | {31'd0, work_q[SHIFT_BITS-1]};

  assign tube_cs = tube_write;
  assign busy    = (state != IDLE) | tube_write;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = LOAD;
      LOAD:    if (!work_q[31] || dec_ovf) state_nxt = DONE;
               else                        state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (pending || commit) state_nxt = LOAD;
               else                   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CPU registers and the single-deep pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_reg  <= '0;
      hi_reg  <= '0;
      pending <= 1'b0;
    end else begin
      if (lo_wr)  lo_reg <= wdata;
      if (commit) hi_reg <= wdata;
      if (state == DONE)                  pending <= 1'b0;
      else if (commit && (state != IDLE)) pending <= 1'b1;
    end
  end

  // Conversion datapath: snapshot, result preset in LOAD, one dabble step per SHIFT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      if (take_snap) work_q <= raw_nxt;
      case (state)
        LOAD: begin
          cnt <= '0;
          if (!work_q[31])  acc <= work_q;
          else if (dec_ovf) acc <= OVF_CODE;
          else              acc <= '0;
        end
        SHIFT: begin
          acc    <= acc_shift;
          work_q <= work_q << 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered tube outputs: one-cycle strobe on leaving DONE, data held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tube_data  <= '0;
      tube_write <= 1'b0;
    end else begin
      tube_write <= (state == DONE);
      if (state == DONE) tube_data <= acc;
    end
  end

endmodule

// File: tb/tb_dig_bcd_feeder.sv
// Directed bench for dig_bcd_feeder: hex, decimal, overflow, pending and reset-abort cases.
// All stimulus changes and all sampling happen on the falling clock edge.
// Expected values are hand-computed constants.
module tb_dig_bcd_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        digcs, digwrite;
  logic [1:0]  digaddr;
  logic [15:0] wdata;
  logic [31:0] tube_data;
  logic        tube_write, tube_cs, busy;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int cyc;
  int base;
  logic dropped;

  dig_bcd_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .digcs      (digcs),
    .digwrite   (digwrite),
    .digaddr    (digaddr),
    .wdata      (wdata),
    .tube_data  (tube_data),
    .tube_write (tube_write),
    .tube_cs    (tube_cs),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count strobe cycles; reads the value held through the preceding cycle
  always @(posedge clk) if (tube_write) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sits on a falling edge; the write is sampled on the next rising edge
  task automatic cpu_wr(input logic [1:0] a, input logic [15:0] d);
    digcs = 1'b1; digwrite = 1'b1; digaddr = a; wdata = d;
    @(negedge clk);
    digcs = 1'b0; digwrite = 1'b0; digaddr = 2'b01; wdata = 16'h0;
  endtask

  // Cycles from now until tube_write is seen high; maxc+1 on timeout
  task automatic wait_pulse(input int maxc, output int c, output logic busy_low);
    c = maxc + 1;
    busy_low = 1'b0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (!busy) busy_low = 1'b1;
      if (tube_write) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; digcs = 1'b0; digwrite = 1'b0; digaddr = 2'b00; wdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_tube_data", tube_data, 32'h0);
    chk("rst_tube_write", {31'd0, tube_write}, 32'd0);
    chk("rst_tube_cs", {31'd0, tube_cs}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Low-half write alone never starts a conversion
    base = pulse_cnt;
    cpu_wr(2'b00, 16'h0002);
    repeat (4) @(negedge clk);
    chk("lo_only_busy", {31'd0, busy}, 32'd0);
    chk("lo_only_pulses", pulse_cnt - base, 32'd0);

    // Hex passthrough of 2
    cpu_wr(2'b10, 16'h0000);
    chk("hex2_busy", {31'd0, busy}, 32'd1);
    wait_pulse(40, cyc, dropped);
    chk("hex2_latency", cyc, 32'd2);
    chk("hex2_data", tube_data, 32'h0000_0002);
    chk("hex2_cs", {31'd0, tube_cs}, 32'd1);
    @(negedge clk);
    chk("hex2_pulse_end", {31'd0, tube_write}, 32'd0);
    chk("hex2_idle", {31'd0, busy}, 32'd0);
    chk("hex2_hold", tube_data, 32'h0000_0002);

    // Decimal 20095
    cpu_wr(2'b00, 16'h4E7F);
    cpu_wr(2'b10, 16'h8000);
    wait_pulse(40, cyc, dropped);
    chk("dec20095_latency", cyc, 32'd29);
    chk("dec20095_busy", {31'd0, dropped}, 32'd0);
    chk("dec20095_data", tube_data, 32'h0002_0095);
    @(negedge clk);

    // Largest decimal value 99,999,999 = 0x5F5E0FF
    cpu_wr(2'b00, 16'hE0FF);
    cpu_wr(2'b10, 16'h85F5);
    wait_pulse(40, cyc, dropped);
    chk("decmax_latency", cyc, 32'd29);
    chk("decmax_data", tube_data, 32'h9999_9999);
    @(negedge clk);

    // 100,000,000 = 0x5F5E100 overflows
    cpu_wr(2'b00, 16'hE100);
    cpu_wr(2'b10, 16'h85F5);
    wait_pulse(40, cyc, dropped);
    chk("ovf_latency", cyc, 32'd2);
    chk("ovf_data", tube_data, 32'hEEEE_EEEE);
    @(negedge clk);

    // Hex with nibbles above 9 passes through unaltered
    cpu_wr(2'b00, 16'hCDEF);
    cpu_wr(2'b10, 16'h12AB);
    wait_pulse(40, cyc, dropped);
    chk("hexbig_latency", cyc, 32'd2);
    chk("hexbig_data", tube_data, 32'h12AB_CDEF);
    @(negedge clk);

    // Decimal 12, then 34 and 56 committed mid-conversion: only 12 and 56 appear
    base = pulse_cnt;
    cpu_wr(2'b00, 16'h000C);
    cpu_wr(2'b10, 16'h8000);
    cpu_wr(2'b00, 16'h0022);
    cpu_wr(2'b10, 16'h8000);
    cpu_wr(2'b00, 16'h0038);
    cpu_wr(2'b10, 16'h8000);
    wait_pulse(40, cyc, dropped);
    chk("pend_first_latency", cyc, 32'd25);
    chk("pend_first_data", tube_data, 32'h0000_0012);
    chk("pend_first_busy", {31'd0, dropped}, 32'd0);
    wait_pulse(40, cyc, dropped);
    chk("pend_second_latency", cyc, 32'd29);
    chk("pend_second_data", tube_data, 32'h0000_0056);
    chk("pend_second_busy", {31'd0, dropped}, 32'd0);
    repeat (40) @(negedge clk);
    chk("pend_pulse_count", pulse_cnt - base, 32'd2);
    chk("pend_idle", {31'd0, busy}, 32'd0);

    // Reset at shift step 10 aborts a decimal conversion
    base = pulse_cnt;
    cpu_wr(2'b00, 16'h4E7F);
    cpu_wr(2'b10, 16'h8000);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rst_data", tube_data, 32'h0);
    chk("abort_rst_write", {31'd0, tube_write}, 32'd0);
    chk("abort_rst_cs", {31'd0, tube_cs}, 32'd0);
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (35) @(negedge clk);
    chk("abort_no_pulse", pulse_cnt - base, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    cpu_wr(2'b00, 16'h00AB);
    cpu_wr(2'b10, 16'h0000);
    wait_pulse(40, cyc, dropped);
    chk("post_rst_latency", cyc, 32'd2);
    chk("post_rst_data", tube_data, 32'h0000_00AB);
    @(negedge clk);
    chk("post_rst_pulse_end", {31'd0, tube_write}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
